mmio_uart_tx: RTL

- Memory-mapped transmit peripheral on the processor data bus (rw_addr / w / w_en / r); it is the responder that consumes processor stores.
- A store to the TX address pushes a byte into a FIFO. An 8N1 serial transmitter drains the FIFO onto txd.
- A status register is readable at a second address. The top-level read mux selects this block's r whenever hit=1, otherwise the SRAM read data.

---
 rtl/mmio_uart_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a store to TX_ADDR queues a byte, and the serial FSM drains the FIFO onto txd.
// Optional even-parity bit is enabled by defining MMIO_UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [7:0]  TX_ADDR      = 8'hFF,
    parameter logic [7:0]  STAT_ADDR    = 8'hFE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rw_addr,
    input  logic [7:0] w,
    input  logic       w_en,
    output logic [7:0] r,
    output logic       hit,
    output logic       txd,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle high, waiting for a queued byte
    // START  | start bit (low)
    // DATA   | 8 data bits, LSB first
    // PARITY | even parity bit (parity build only)
    // STOP   | stop bit (high); chains straight into START if more data is queued

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam int             CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);

`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    localparam logic PAR_FLAG = 1'b0;
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      tx_data;
    logic            pop;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, push;
    logic            overflow;
    logic            tc;
    logic [7:0]      status;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = w_en && (rw_addr == TX_ADDR) && !full;
    assign tc    = (clk_cnt == '0);
    assign busy  = (state != S_IDLE) || !empty;

    assign hit    = (rw_addr == TX_ADDR) || (rw_addr == STAT_ADDR);
    assign status = {PAR_FLAG, 3'b000, overflow, busy, full, empty};

    always_comb begin
        r = 8'h00;
        if (rw_addr == STAT_ADDR) begin
            r = status;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= w;
        end
    end

    // full is the pre-edge value, so a store while full is dropped even if a pop frees a slot on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (w_en && (rw_addr == STAT_ADDR)) begin
                overflow <= 1'b0;
            end else if (w_en && (rw_addr == TX_ADDR) && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_data <= '0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            if (pop) begin
                tx_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_nxt   = S_START;
                    clk_cnt_nxt = CNT_LOAD;
                end
            end
            S_START: begin
                if (tc) begin
                    state_nxt   = S_DATA;
                    clk_cnt_nxt = CNT_LOAD;
                    bit_idx_nxt = 3'd0;
                end else begin
                    clk_cnt_nxt = clk_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tc) begin
                    clk_cnt_nxt = CNT_LOAD;
                    if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt - CNT_ONE;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (tc) begin
                    state_nxt   = S_STOP;
                    clk_cnt_nxt = CNT_LOAD;
                end else begin
                    clk_cnt_nxt = clk_cnt - CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (tc) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        state_nxt   = S_START;
                        clk_cnt_nxt = CNT_LOAD;
                    end else begin
                        state_nxt   = S_IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // txd decodes straight from the state register so an async reset returns the line high at once
    always_comb begin
        txd = 1'b1;
        case (state)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_data[bit_idx];
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: txd = ^tx_data;
`endif
            default: txd = 1'b1;
        endcase
    end

endmodule
